micro_sequencer: RTL and testbench

Microprogrammed controller that sequences the ALU/shifter register-file datapath (INSTRUCTION_CONNECTION). It holds a writable control store and steps through microwords. Each microword drives alu_shifter_opcode, c_select and b_select for one datapath operation, then chooses the next address from the datapath n/z flags. A host loads the program, pulses start, and waits for done.

---
 rtl/micro_seq_defs_pkg.sv | 43 ++++
 rtl/micro_store.sv | 24 ++
 rtl/micro_sequencer.sv | 116 +++++++++++
 tb/tb_micro_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/micro_seq_defs_pkg.sv
// rtl/micro_seq_defs_pkg.sv - microword layout, condition codes and sequencer states
package micro_seq_defs;

    localparam int OP_LSB   = 0;
    localparam int OP_W     = 8;
    localparam int C_LSB    = 8;
    localparam int C_W      = 9;
    localparam int B_LSB    = 17;
    localparam int B_W      = 4;
    localparam int COND_LSB = 21;
    localparam int COND_W   = 3;
    localparam int TGT_LSB  = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        COND_SEQ  = 3'd0,
        COND_JMP  = 3'd1,
        COND_JN   = 3'd2,
        COND_JZ   = 3'd3,
        COND_JNN  = 3'd4,
        COND_JNZ  = 3'd5,
        COND_HALT = 3'd6,
        COND_RSVD = 3'd7
    } cond_t;

    // HALT and the reserved code never branch; HALT is handled by the FSM
    function automatic logic branch_taken(input cond_t cond, input logic n, input logic z);
        case (cond)
            COND_JMP: branch_taken = 1'b1;
            COND_JN:  branch_taken = n;
            COND_JZ:  branch_taken = z;
            COND_JNN: branch_taken = ~n;
            COND_JNZ: branch_taken = ~z;
            default:  branch_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/micro_store.sv
// rtl/micro_store.sv - writable control store, synchronous write, asynchronous read
module micro_store #(
    parameter int ADDR_W = 6,
    parameter int MW     = 30
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [MW-1:0]     wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [MW-1:0]     rdata
);

    logic [MW-1:0] mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - microprogrammed controller for the ALU/shifter datapath
module micro_sequencer
    import micro_seq_defs::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    start_addr,
    input  logic                 prog_we,
    input  logic [ADDR_W-1:0]    prog_addr,
    input  logic [24+ADDR_W-1:0] prog_data,
    input  logic                 n,
    input  logic                 z,
    output logic [7:0]           alu_shifter_opcode,
    output logic [8:0]           c_select,
    output logic [3:0]           b_select,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    upc,
    output logic [15:0]          uop_count
);

    localparam int MW = 24 + ADDR_W;

    state_t            state, state_n;
    cond_t             cond_r, cond_n;
    logic [ADDR_W-1:0] tgt_r, tgt_n;
    logic [ADDR_W-1:0] upc_n;
    logic [7:0]        op_n;
    logic [8:0]        c_n;
    logic [3:0]        b_n;
    logic [15:0]       cnt_n;
    logic              done_n;
    logic [MW-1:0]     word;

    // Writes are locked out while running so the program never changes under itself
    micro_store #(.ADDR_W(ADDR_W), .MW(MW)) u_store (
        .clock (clock),
        .we    (prog_we && (state == ST_IDLE)),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (upc),
        .rdata (word)
    );

    always_comb begin
        state_n = state;
        cond_n  = cond_r;
        tgt_n   = tgt_r;
        upc_n   = upc;
        op_n    = '0;
        c_n     = '0;
        b_n     = '0;
        cnt_n   = uop_count;
        done_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    upc_n   = start_addr;
                    cnt_n   = '0;
                    state_n = ST_FETCH;
                end
            end
            ST_FETCH: begin
                op_n    = word[OP_LSB +: OP_W];
                c_n     = word[C_LSB +: C_W];
                b_n     = word[B_LSB +: B_W];
                cond_n  = cond_t'(word[COND_LSB +: COND_W]);
                tgt_n   = word[TGT_LSB +: ADDR_W];
                state_n = ST_EXEC;
            end
            ST_EXEC: begin
                if (uop_count != 16'hFFFF) begin
                    cnt_n = uop_count + 16'd1;
                end
                if (cond_r == COND_HALT) begin
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    upc_n   = branch_taken(cond_r, n, z) ? tgt_r : ADDR_W'(upc + 1'b1);
                    state_n = ST_FETCH;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= ST_IDLE;
            cond_r             <= COND_SEQ;
            tgt_r              <= '0;
            upc                <= '0;
            alu_shifter_opcode <= '0;
            c_select           <= '0;
            b_select           <= '0;
            uop_count          <= '0;
            done               <= 1'b0;
        end else begin
            state              <= state_n;
            cond_r             <= cond_n;
            tgt_r              <= tgt_n;
            upc                <= upc_n;
            alu_shifter_opcode <= op_n;
            c_select           <= c_n;
            b_select           <= b_n;
            uop_count          <= cnt_n;
            done               <= done_n;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - directed self-checking bench for micro_sequencer
module tb_micro_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  start_addr = '0;
    logic        prog_we = 1'b0;
    logic [5:0]  prog_addr = '0;
    logic [29:0] prog_data = '0;
    logic        n = 1'b0;
    logic        z = 1'b0;
    logic [7:0]  alu_shifter_opcode;
    logic [8:0]  c_select;
    logic [3:0]  b_select;
    logic        busy;
    logic        done;
    logic [5:0]  upc;
    logic [15:0] uop_count;

    int n_vec = 0;
    int n_err = 0;

    micro_sequencer #(.ADDR_W(6)) dut (
        .clock              (clock),
        .reset              (reset),
        .start              (start),
        .start_addr         (start_addr),
        .prog_we            (prog_we),
        .prog_addr          (prog_addr),
        .prog_data          (prog_data),
        .n                  (n),
        .z                  (z),
        .alu_shifter_opcode (alu_shifter_opcode),
        .c_select           (c_select),
        .b_select           (b_select),
        .busy               (busy),
        .done               (done),
        .upc                (upc),
        .uop_count          (uop_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  cond;
        logic        fn;
        logic        fz;
        logic [5:0]  exp_upc;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [29:0] mk(input logic [7:0] op, input logic [8:0] c,
                                       input logic [3:0] b, input logic [2:0] cond,
                                       input logic [5:0] tgt);
        return {tgt, cond, b, c, op};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic write_word(input logic [5:0] a, input logic [29:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        step();
        prog_we   = 1'b0;
    endtask

    task automatic pulse_start(input logic [5:0] sa);
        start      = 1'b1;
        start_addr = sa;
        step();
        start      = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int i;
        for (i = 0; i < 200; i++) begin
            if (done) break;
            step();
        end
        check({name, " done_seen"}, {31'd0, done}, 32'd1);
    endtask

    logic [29:0] halt_w;

    initial begin
        halt_w = mk(8'h00, 9'h000, 4'h0, 3'd6, 6'd0);

        vecs[0]  = '{3'd0, 1'b0, 1'b0, 6'd1, 16'd2};
        vecs[1]  = '{3'd1, 1'b0, 1'b0, 6'd5, 16'd2};
        vecs[2]  = '{3'd2, 1'b1, 1'b0, 6'd5, 16'd2};
        vecs[3]  = '{3'd2, 1'b0, 1'b1, 6'd1, 16'd2};
        vecs[4]  = '{3'd3, 1'b0, 1'b1, 6'd5, 16'd2};
        vecs[5]  = '{3'd3, 1'b1, 1'b0, 6'd1, 16'd2};
        vecs[6]  = '{3'd4, 1'b0, 1'b1, 6'd5, 16'd2};
        vecs[7]  = '{3'd4, 1'b1, 1'b0, 6'd1, 16'd2};
        vecs[8]  = '{3'd5, 1'b1, 1'b0, 6'd5, 16'd2};
        vecs[9]  = '{3'd5, 1'b0, 1'b1, 6'd1, 16'd2};
        vecs[10] = '{3'd6, 1'b1, 1'b1, 6'd0, 16'd1};
        vecs[11] = '{3'd7, 1'b0, 1'b0, 6'd1, 16'd2};

        step();
        step();
        reset = 1'b0;
        repeat (5) step();
        check("rst_op", {24'd0, alu_shifter_opcode}, 32'd0);
        check("rst_c", {23'd0, c_select}, 32'd0);
        check("rst_b", {28'd0, b_select}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_upc", {26'd0, upc}, 32'd0);
        check("rst_cnt", {16'd0, uop_count}, 32'd0);

        // basic timing: SEQ word then HALT
        write_word(6'd0, mk(8'h31, 9'h002, 4'h1, 3'd0, 6'd0));
        write_word(6'd1, halt_w);
        pulse_start(6'd0);
        check("t1_fetch_c", {23'd0, c_select}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd1);
        step();
        check("t2_op", {24'd0, alu_shifter_opcode}, 32'h31);
        check("t2_c", {23'd0, c_select}, 32'h002);
        check("t2_b", {28'd0, b_select}, 32'h1);
        step();
        check("t3_op", {24'd0, alu_shifter_opcode}, 32'h00);
        check("t3_c", {23'd0, c_select}, 32'd0);
        step();
        check("t4_done", {31'd0, done}, 32'd0);
        step();
        check("t5_done", {31'd0, done}, 32'd1);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_cnt", {16'd0, uop_count}, 32'd2);
        check("t5_upc", {26'd0, upc}, 32'd1);
        step();
        check("t6_done", {31'd0, done}, 32'd0);

        // condition table
        write_word(6'd5, halt_w);
        for (int i = 0; i < 12; i++) begin
            write_word(6'd0, mk(8'h40 + 8'(i), 9'h001, 4'h2, vecs[i].cond, 6'd5));
            n = vecs[i].fn;
            z = vecs[i].fz;
            pulse_start(6'd0);
            step();
            check($sformatf("v%0d_op", i), {24'd0, alu_shifter_opcode}, 32'h40 + 32'(i));
            wait_done($sformatf("v%0d", i));
            check($sformatf("v%0d_upc", i), {26'd0, upc}, {26'd0, vecs[i].exp_upc});
            check($sformatf("v%0d_cnt", i), {16'd0, uop_count}, {16'd0, vecs[i].exp_cnt});
            step();
        end
        n = 1'b0;
        z = 1'b0;

        // upc wraps 63 -> 0
        write_word(6'd63, mk(8'h77, 9'h004, 4'h3, 3'd0, 6'd0));
        write_word(6'd0, halt_w);
        pulse_start(6'd63);
        step();
        check("wrap_op", {24'd0, alu_shifter_opcode}, 32'h77);
        step();
        check("wrap_upc0", {26'd0, upc}, 32'd0);
        wait_done("wrap");
        check("wrap_upc", {26'd0, upc}, 32'd0);
        check("wrap_cnt", {16'd0, uop_count}, 32'd2);
        step();

        // start and prog_we ignored while busy
        write_word(6'd0, mk(8'h11, 9'h001, 4'h0, 3'd0, 6'd0));
        write_word(6'd1, mk(8'h22, 9'h001, 4'h0, 3'd0, 6'd0));
        write_word(6'd2, halt_w);
        pulse_start(6'd0);
        start      = 1'b1;
        start_addr = 6'd10;
        prog_we    = 1'b1;
        prog_addr  = 6'd1;
        prog_data  = halt_w;
        repeat (3) step();
        start   = 1'b0;
        prog_we = 1'b0;
        wait_done("lock");
        check("lock_upc", {26'd0, upc}, 32'd2);
        check("lock_cnt", {16'd0, uop_count}, 32'd3);
        step();
        pulse_start(6'd1);
        step();
        check("lock_store1", {24'd0, alu_shifter_opcode}, 32'h22);
        wait_done("lock2");
        step();

        // reset during EXEC
        write_word(6'd0, mk(8'h55, 9'h100, 4'h4, 3'd0, 6'd0));
        write_word(6'd1, halt_w);
        pulse_start(6'd0);
        step();
        check("rx_c", {23'd0, c_select}, 32'h100);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rx_c0", {23'd0, c_select}, 32'd0);
        check("rx_busy", {31'd0, busy}, 32'd0);
        check("rx_upc", {26'd0, upc}, 32'd0);
        check("rx_cnt", {16'd0, uop_count}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rx_nodone%0d", i), {31'd0, done}, 32'd0);
            step();
        end
        check("rx_idle_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
